// File: rtl/axi_mem_arbiter_pkg.sv
// Shared encodings for the fetch/data AXI arbiter: FSM states, owner, access sizes, AXI constants.
// Pure definitions; no logic, no latency.
package axi_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_ADDR = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // Latched copy of the granted request, held for the whole transaction.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } txn_t;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Store byte-lane strobe decoder from access size and address low bits.
// Purely combinational, zero latency, no flow control.
module axi_wstrb_gen
    import axi_mem_arbiter_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] wstrb
);

    always_comb begin
        wstrb = 4'b1111;
        case (size)
            SZ_BYTE: wstrb = 4'b0001 << addr_lo;
            SZ_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
            default: wstrb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI master between fetch and data requesters, one single-beat transaction at a time, data first.
// Grant on the IDLE edge, valids one cycle later; holds each channel until the slave accepts; *_ok pulses in DONE.
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ok,
    output logic        inst_stall,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ok,
    output logic        data_stall,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    state_t state;
    owner_t owner;
    txn_t   txn;
    logic   aw_done;
    logic   w_done;
    logic   aw_fin;
    logic   w_fin;
    logic   unused_rlast;

    // Single-beat reads: the last flag carries no information.
    assign unused_rlast = rlast;

    assign aw_fin = aw_done | (awvalid & awready);
    assign w_fin  = w_done  | (wvalid  & wready);

    assign inst_stall = inst_req & ~inst_ok;
    assign data_stall = data_req & ~data_ok;

    assign arid   = (owner == OWN_DATA) ? DATA_ID : INST_ID;
    assign araddr = txn.addr;
    assign arlen  = AXI_LEN_SINGLE;
    assign arsize = axi_size(txn.size);

    assign awid   = DATA_ID;
    assign awaddr = txn.addr;
    assign awlen  = AXI_LEN_SINGLE;
    assign awsize = axi_size(txn.size);

    assign wdata  = txn.wdata;
    assign wlast  = wvalid;

    axi_wstrb_gen u_wstrb (
        .size    (txn.size),
        .addr_lo (txn.addr[1:0]),
        .wstrb   (wstrb)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            owner      <= OWN_INST;
            txn        <= '0;
            arvalid    <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            rready     <= 1'b0;
            bready     <= 1'b0;
            inst_ok    <= 1'b0;
            data_ok    <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
        end else begin
            inst_ok <= 1'b0;
            data_ok <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (data_req) begin
                        txn   <= '{addr: data_addr, wdata: data_wdata, size: data_size};
                        owner <= OWN_DATA;
                        if (data_wr) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= ST_WR_ADDR;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= ST_RD_ADDR;
                        end
                    end else if (inst_req) begin
                        txn     <= '{addr: inst_addr, wdata: 32'd0, size: SZ_WORD};
                        owner   <= OWN_INST;
                        arvalid <= 1'b1;
                        state   <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid && rready) begin
                        rready <= 1'b0;
                        if (owner == OWN_DATA) begin
                            data_rdata <= rdata;
                            data_ok    <= 1'b1;
                        end else begin
                            inst_rdata <= rdata;
                            inst_ok    <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_WR_ADDR: begin
                    // AW and W retire independently; move on once both have been accepted.
                    if (awvalid && awready) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid && bready) begin
                        bready <= 1'b0;
                        if (owner == OWN_DATA) begin
                            data_ok <= 1'b1;
                        end else begin
                            inst_ok <= 1'b1;
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // No grant here, so a requester still holding req after its ok is not re-served.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: table of fetch/load/store vectors against a delay-programmable AXI slave,
// scoreboard queue of expected completions, plus hand sequences for priority, reset and back-to-back.
module tb_axi_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ok;
    logic        inst_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ok;
    logic        data_stall;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rlast;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    axi_mem_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_ok    (inst_ok),
        .inst_stall (inst_stall),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_size  (data_size),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_ok    (data_ok),
        .data_stall (data_stall),
        .arid       (arid),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rready     (rready),
        .awid       (awid),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    // d0 = AR or AW ready delay, d1 = R or W delay, b = B delay; extra = cycles queued behind a DONE.
    typedef struct {
        bit          is_inst;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          d0;
        int          d1;
        int          b;
        logic [3:0]  strb;
        int          extra;
    } vec_t;

    typedef struct {
        int          ar;
        int          r;
        int          aw;
        int          w;
        int          b;
        logic [31:0] rdat;
    } slv_t;

    typedef struct {
        bit          is_inst;
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        logic [2:0]  size;
        logic [3:0]  strb;
        int          lat;
    } exp_t;

    localparam int NV = 13;
    vec_t tbl [NV];
    slv_t slv_q [$];
    exp_t exp_q [$];

    int checks = 0;
    int failures = 0;
    int ar_count = 0;
    int aw_count = 0;
    int done_count = 0;
    int aborted = 0;
    int unexp = 0;
    int viol = 0;
    logic [31:0] model_drdata = 32'd0;

    logic [3:0]  obs_arid;
    logic [31:0] obs_araddr;
    logic [2:0]  obs_arsize;
    logic [7:0]  obs_arlen;
    logic [3:0]  obs_awid;
    logic [31:0] obs_awaddr;
    logic [2:0]  obs_awsize;
    logic [7:0]  obs_awlen;
    logic [3:0]  obs_wstrb;
    logic [31:0] obs_wdata;
    logic        obs_wlast;
    logic        obs_wpair;

    int   rd_st, wr_st, rd_cnt, aw_cnt, w_cnt, b_cnt;
    bit   aw_ok, w_ok;
    slv_t rcfg, wcfg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // AXI slave: drives on negedges, latency per transaction taken from slv_q.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rlast = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rd_st = 0; wr_st = 0; rd_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_ok = 1'b0; w_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
                rd_st = 0; wr_st = 0;
            end else begin
                if (bready && (awvalid || wvalid)) viol++;
                if (arvalid && (awvalid || wvalid)) viol++;
                if (rready && arvalid) viol++;
                case (rd_st)
                    0: if (arvalid) begin
                        obs_arid = arid; obs_araddr = araddr; obs_arsize = arsize; obs_arlen = arlen;
                        ar_count++;
                        if (slv_q.size() > 0) rcfg = slv_q.pop_front();
                        else begin unexp++; rcfg = '{0, 0, 0, 0, 0, 32'h0}; end
                        rd_cnt = rcfg.ar;
                        arready = (rd_cnt == 0);
                        rd_st = 1;
                    end
                    1: if (arready) begin
                        arready = 1'b0;
                        rd_cnt = rcfg.r;
                        if (rd_cnt == 0) begin rvalid = 1'b1; rdata = rcfg.rdat; rlast = 1'b1; end
                        rd_st = 2;
                    end else begin
                        rd_cnt--;
                        if (rd_cnt == 0) arready = 1'b1;
                    end
                    default: if (rvalid) begin
                        rvalid = 1'b0; rlast = 1'b0; rd_st = 0;
                    end else begin
                        rd_cnt--;
                        if (rd_cnt == 0) begin rvalid = 1'b1; rdata = rcfg.rdat; rlast = 1'b1; end
                    end
                endcase
                case (wr_st)
                    0: if (awvalid) begin
                        obs_awid = awid; obs_awaddr = awaddr; obs_awsize = awsize; obs_awlen = awlen;
                        obs_wstrb = wstrb; obs_wdata = wdata; obs_wlast = wlast; obs_wpair = wvalid;
                        aw_count++;
                        if (slv_q.size() > 0) wcfg = slv_q.pop_front();
                        else begin unexp++; wcfg = '{0, 0, 0, 0, 0, 32'h0}; end
                        aw_cnt = wcfg.aw; w_cnt = wcfg.w;
                        awready = (aw_cnt == 0); wready = (w_cnt == 0);
                        aw_ok = 1'b0; w_ok = 1'b0;
                        wr_st = 1;
                    end
                    1: begin
                        if (!aw_ok) begin
                            if (awready) begin awready = 1'b0; aw_ok = 1'b1; end
                            else begin aw_cnt--; if (aw_cnt == 0) awready = 1'b1; end
                        end
                        if (!w_ok) begin
                            if (wready) begin wready = 1'b0; w_ok = 1'b1; end
                            else begin w_cnt--; if (w_cnt == 0) wready = 1'b1; end
                        end
                        if (aw_ok && w_ok) begin
                            b_cnt = wcfg.b;
                            if (b_cnt == 0) bvalid = 1'b1;
                            wr_st = 2;
                        end
                    end
                    default: if (bvalid) begin
                        bvalid = 1'b0; wr_st = 0;
                    end else begin
                        b_cnt--;
                        if (b_cnt == 0) bvalid = 1'b1;
                    end
                endcase
            end
        end
    end

    task automatic issue(input vec_t v);
        exp_t e;
        slv_t s;
        s = '{v.d0, v.d1, v.d0, v.d1, v.b, v.rdat};
        slv_q.push_back(s);
        e.is_inst = v.is_inst;
        e.wr      = v.wr;
        e.id      = v.is_inst ? 4'd0 : 4'd1;
        e.addr    = v.addr;
        e.wdat    = v.wdat;
        e.size    = v.is_inst ? 3'd2 : {1'b0, v.size};
        e.strb    = v.strb;
        if (v.wr) begin
            e.rdat = model_drdata;
            e.lat  = 3 + ((v.d0 > v.d1) ? v.d0 : v.d1) + v.b;
        end else begin
            e.rdat = v.rdat;
            e.lat  = 3 + v.d0 + v.d1;
            if (!v.is_inst) model_drdata = v.rdat;
        end
        e.lat = e.lat + v.extra;
        exp_q.push_back(e);
        if (v.is_inst) begin
            inst_req  = 1'b1;
            inst_addr = v.addr;
        end else begin
            data_req   = 1'b1;
            data_wr    = v.wr;
            data_size  = v.size;
            data_addr  = v.addr;
            data_wdata = v.wdat;
        end
    endtask

    task automatic wait_ok();
        exp_t e;
        int   n;
        bit   got;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("stall_while_pending", 32'(e.is_inst ? inst_stall : data_stall), 32'd1);
                chk("ok_low_after_done", 32'({inst_ok, data_ok}), 32'd0);
            end
            if (inst_ok || data_ok) got = 1'b1;
        end
        if (!got) begin
            failures++;
            $display("FAIL ok_timeout: got no ok after %0d cycles expected latency %0d", n, e.lat);
            return;
        end
        chk("ok_owner", 32'({inst_ok, data_ok}), e.is_inst ? 32'd2 : 32'd1);
        chk("latency", 32'(n), 32'(e.lat));
        chk("rdata", e.is_inst ? inst_rdata : data_rdata, e.rdat);
        chk("stall_drops_at_ok", 32'(e.is_inst ? inst_stall : data_stall), 32'd0);
        chk("valids_low_at_ok", 32'({arvalid, awvalid, wvalid}), 32'd0);
        done_count++;
        chk("axi_txn_count", 32'(ar_count + aw_count), 32'(done_count + aborted));
        if (e.wr) begin
            chk("awid", 32'(obs_awid), 32'(e.id));
            chk("awaddr", obs_awaddr, e.addr);
            chk("awsize", 32'(obs_awsize), 32'(e.size));
            chk("awlen", 32'(obs_awlen), 32'd0);
            chk("wstrb", 32'(obs_wstrb), 32'(e.strb));
            chk("wdata", obs_wdata, e.wdat);
            chk("wlast_wpair", 32'({obs_wlast, obs_wpair}), 32'd3);
        end else begin
            chk("arid", 32'(obs_arid), 32'(e.id));
            chk("araddr", obs_araddr, e.addr);
            chk("arsize", 32'(obs_arsize), 32'(e.size));
            chk("arlen", 32'(obs_arlen), 32'd0);
        end
    endtask

    initial begin
        vec_t v;
        bit   seen;
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;

        //          inst  wr    size  addr          wdata         rdata         d0 d1 b  strb     extra
        tbl[0]  = '{1'b1, 1'b0, 2'd2, 32'hBFC00000, 32'h00000000, 32'h3C08BFC0, 2, 3, 0, 4'b0000, 0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 32'h80000003, 32'hAB000000, 32'h00000000, 0, 1, 1, 4'b1000, 0};
        tbl[2]  = '{1'b0, 1'b1, 2'd1, 32'h80000102, 32'h12340000, 32'h00000000, 0, 0, 0, 4'b1100, 0};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, 32'h80000200, 32'hDEADBEEF, 32'h00000000, 1, 1, 2, 4'b1111, 0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 32'h80000011, 32'h0000CD00, 32'h00000000, 2, 0, 0, 4'b0010, 0};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 32'h80000020, 32'h00005678, 32'h00000000, 0, 0, 1, 4'b0011, 0};
        tbl[6]  = '{1'b0, 1'b1, 2'd3, 32'h80000030, 32'hCAFEBABE, 32'h00000000, 0, 1, 0, 4'b1111, 0};
        tbl[7]  = '{1'b0, 1'b0, 2'd2, 32'h80001004, 32'h00000000, 32'h11223344, 0, 0, 0, 4'b0000, 0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 32'h80001007, 32'h00000000, 32'h55667788, 1, 2, 0, 4'b0000, 0};
        tbl[9]  = '{1'b0, 1'b0, 2'd1, 32'h80001008, 32'h00000000, 32'h99AABBCC, 0, 1, 0, 4'b0000, 1};
        tbl[10] = '{1'b0, 1'b0, 2'd2, 32'h8000100C, 32'h00000000, 32'h0BADF00D, 1, 0, 0, 4'b0000, 1};
        tbl[11] = '{1'b1, 1'b0, 2'd2, 32'hBFC00004, 32'h00000000, 32'h27BDFFE8, 0, 1, 0, 4'b0000, 0};
        tbl[12] = '{1'b0, 1'b1, 2'd2, 32'h80000040, 32'h01020304, 32'h00000000, 0, 0, 0, 4'b1111, 0};

        repeat (3) @(negedge clk);
        chk("reset_handshakes", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("reset_oks", 32'({inst_ok, data_ok, inst_stall, data_stall}), 32'd0);
        chk("reset_inst_rdata", inst_rdata, 32'd0);
        chk("reset_data_rdata", data_rdata, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i]);
            wait_ok();
            if (i + 1 < NV && tbl[i + 1].extra != 0) continue;
            inst_req = 1'b0;
            data_req = 1'b0;
            @(negedge clk);
            chk("idle_after_done", 32'({arvalid, awvalid, wvalid, inst_ok, data_ok}), 32'd0);
        end

        // Simultaneous requests: data must be served first, fetch only after DONE plus one IDLE cycle.
        v = '{1'b0, 1'b0, 2'd2, 32'h80001004, 32'h0, 32'hCAFEF00D, 0, 0, 0, 4'b0000, 0};
        issue(v);
        v = '{1'b1, 1'b0, 2'd2, 32'hBFC00010, 32'h0, 32'h24020001, 0, 0, 0, 4'b0000, 1};
        issue(v);
        wait_ok();
        chk("inst_stall_behind_data", 32'(inst_stall), 32'd1);
        data_req = 1'b0;
        wait_ok();
        inst_req = 1'b0;
        @(negedge clk);

        // Reset while the slave is still holding back R data.
        slv_q.push_back('{0, 10, 0, 0, 0, 32'h77777777});
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80002000;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rready) seen = 1'b1;
        end
        if (!seen) begin
            failures++;
            $display("FAIL reach_rd_data: got rready=0 expected rready=1 within 20 cycles");
        end
        @(negedge clk);
        resetn = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        chk("midreset_handshakes", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("midreset_oks", 32'({inst_ok, data_ok}), 32'd0);
        chk("midreset_data_rdata", data_rdata, 32'd0);
        chk("midreset_inst_rdata", inst_rdata, 32'd0);
        aborted = 1;
        model_drdata = 32'd0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        v = '{1'b0, 1'b0, 2'd2, 32'h80002004, 32'h0, 32'h13572468, 1, 1, 0, 4'b0000, 0};
        issue(v);
        wait_ok();
        data_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("protocol_violations", 32'(viol), 32'd0);
        chk("unexpected_axi", 32'(unexp), 32'd0);
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
        chk("axi_total", 32'(ar_count + aw_count), 32'(done_count + aborted));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
